// File: rtl/conv_sched_pkg.sv
// Shared definitions for the conv scheduler: FSM states, weight word width,
// layer encodings and counter widths.
package conv_sched_pkg;

  // Weight bits per kernel (3x3 binary kernel)
  localparam int KW        = 9;
  // Serializer position counter must reach KW
  localparam int SER_CNT_W = $clog2(KW + 1);
  // RUN cycle counter; saturates, wide enough for any practical watchdog limit
  localparam int RUN_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    RUN,
    GAP
  } state_t;

  typedef enum logic {
    L0_28 = 1'b0,
    L1_12 = 1'b1
  } layer_t;

endpackage

// File: rtl/conv_sched_if.sv
// Bundle of the scheduler's command, weight ROM, conv engine and tag signals.
// master: the scheduler itself; slave: layer controller / ROM / conv pair.
interface conv_sched_if
  import conv_sched_pkg::*;
#(
  parameter int KIDX_W = 4
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_layer;
  logic [KIDX_W-1:0] cmd_nk;
  logic [7:0]        cmd_base;
  logic              wt_rd;
  logic [7:0]        wt_addr;
  logic [KW-1:0]     wt_data;
  logic              conv_state;
  logic              conv_weight_en;
  logic              conv_weight;
  logic              win_start;
  logic              conv_start;
  logic              conv_done;
  logic              conv_ovalid;
  logic              tag_valid;
  logic [KIDX_W-1:0] tag_kidx;
  logic              busy;
  logic              all_done;
  logic              err;

  modport master (
    input  cmd_valid, cmd_layer, cmd_nk, cmd_base, wt_data, conv_done, conv_ovalid,
    output cmd_ready, wt_rd, wt_addr, conv_state, conv_weight_en, conv_weight,
           win_start, conv_start, tag_valid, tag_kidx, busy, all_done, err
  );

  modport slave (
    output cmd_valid, cmd_layer, cmd_nk, cmd_base, wt_data, conv_done, conv_ovalid,
    input  cmd_ready, wt_rd, wt_addr, conv_state, conv_weight_en, conv_weight,
           win_start, conv_start, tag_valid, tag_kidx, busy, all_done, err
  );

endinterface

// File: rtl/conv_wt_ser.sv
// Weight serializer: loads one KW-bit kernel word, then emits a dummy 0 bit
// followed by the word LSB first, with en high for all KW+1 cycles.
// done is high on the last emitted bit.
module conv_wt_ser
  import conv_sched_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [KW-1:0] data,
  output logic          en,
  output logic          wbit,
  output logic          done
);

  logic [KW-1:0]        sh_reg;
  logic [SER_CNT_W-1:0] cnt_reg;
  logic                 active_reg;

  // Load the word, then hold it for the dummy cycle and shift once per real bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_reg     <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
    end else if (load) begin
      sh_reg     <= data;
      cnt_reg    <= '0;
      active_reg <= 1'b1;
    end else if (active_reg) begin
      if (cnt_reg != '0) sh_reg <= sh_reg >> 1;
      if (cnt_reg == SER_CNT_W'(KW)) active_reg <= 1'b0;
      else                           cnt_reg    <= cnt_reg + 1'b1;
    end
  end

  assign en   = active_reg;
  assign wbit = active_reg && (cnt_reg != '0) && sh_reg[0];
  assign done = active_reg && (cnt_reg == SER_CNT_W'(KW));

endmodule

// File: rtl/conv_sched.sv
// Kernel sequencer for one conv layer: per kernel fetch the weight word,
// stream it into the conv engine, run window+conv until conv_done, then
// advance. Optional RUN watchdog is enabled by defining CONV_SCHED_WDOG_EN.
module conv_sched
  import conv_sched_pkg::*;
#(
  parameter int KIDX_W   = 4,
  parameter int CONV_DLY = 1
`ifdef CONV_SCHED_WDOG_EN
  ,
  parameter int WDOG_CYC = 1024
`endif
) (
  input  logic         clk,
  input  logic         rst,
  conv_sched_if.master bus
);

  state_t                 state_reg, state_next;
  logic [KIDX_W-1:0]      kidx_reg, kidx_next;
  logic [KIDX_W-1:0]      nk_reg, nk_next;
  logic [7:0]             base_reg, base_next;
  layer_t                 layer_reg, layer_next;
  logic                   fetch_ph_reg, fetch_ph_next;
  logic [RUN_CNT_W-1:0]   run_cnt_reg, run_cnt_next;
  logic                   all_done_reg, all_done_next;
  logic                   err_reg, err_next;
  logic                   ser_load;
  logic                   ser_done;
  logic                   dly_ok;

  // conv_done only counts once conv_start is up
  assign dly_ok = (run_cnt_reg >= RUN_CNT_W'(CONV_DLY));

  conv_wt_ser u_ser (
    .clk  (clk),
    .rst  (rst),
    .load (ser_load),
    .data (bus.wt_data),
    .en   (bus.conv_weight_en),
    .wbit (bus.conv_weight),
    .done (ser_done)
  );

  // State and command registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      kidx_reg     <= '0;
      nk_reg       <= '0;
      base_reg     <= '0;
      layer_reg    <= L0_28;
      fetch_ph_reg <= 1'b0;
      run_cnt_reg  <= '0;
      all_done_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      kidx_reg     <= kidx_next;
      nk_reg       <= nk_next;
      base_reg     <= base_next;
      layer_reg    <= layer_next;
      fetch_ph_reg <= fetch_ph_next;
      run_cnt_reg  <= run_cnt_next;
      all_done_reg <= all_done_next;
      err_reg      <= err_next;
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_next    = state_reg;
    kidx_next     = kidx_reg;
    nk_next       = nk_reg;
    base_next     = base_reg;
    layer_next    = layer_reg;
    fetch_ph_next = 1'b0;
    run_cnt_next  = run_cnt_reg;
    all_done_next = 1'b0;
    err_next      = 1'b0;
    ser_load      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          layer_next = layer_t'(bus.cmd_layer);
          nk_next    = bus.cmd_nk;
          base_next  = bus.cmd_base;
          kidx_next  = '0;
          if (bus.cmd_nk == '0) all_done_next = 1'b1;
          else                  state_next    = FETCH;
        end
      end
      FETCH: begin
        // phase 0 issues the ROM read, phase 1 captures the returned word
        if (fetch_ph_reg) begin
          ser_load   = 1'b1;
          state_next = LOAD;
        end else begin
          fetch_ph_next = 1'b1;
        end
      end
      LOAD: begin
        if (ser_done) begin
          state_next   = RUN;
          run_cnt_next = '0;
        end
      end
      RUN: begin
        if (run_cnt_reg != '1) run_cnt_next = run_cnt_reg + 1'b1;
        if (dly_ok && bus.conv_done) begin
          state_next = GAP;
        end
`ifdef CONV_SCHED_WDOG_EN
        else if (run_cnt_reg == RUN_CNT_W'(WDOG_CYC - 1)) begin
          err_next   = 1'b1;
          kidx_next  = '0;
          state_next = IDLE;
        end
`endif
      end
      GAP: begin
        // start lines are low here so the engine counters clear between kernels
        if (kidx_reg == nk_reg - 1'b1) begin
          all_done_next = 1'b1;
          kidx_next     = '0;
          state_next    = IDLE;
        end else begin
          kidx_next  = kidx_reg + 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.cmd_ready  = (state_reg == IDLE);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.wt_rd      = (state_reg == FETCH) && !fetch_ph_reg;
  assign bus.wt_addr    = base_reg + 8'(kidx_reg);
  assign bus.conv_state = layer_reg;
  assign bus.win_start  = (state_reg == RUN);
  assign bus.conv_start = (state_reg == RUN) && dly_ok;
  assign bus.tag_valid  = (state_reg == RUN) && bus.conv_ovalid;
  assign bus.tag_kidx   = kidx_reg;
  assign bus.all_done   = all_done_reg;
  assign bus.err        = err_reg;

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched: table of commands with hand-computed
// latencies and strobe counts, plus reset-mid-LOAD and watchdog sequences.
module tb_conv_sched;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   conv_lat;
  bit   withhold;
  bit   ovalid_ext;
  bit   err_seen;
  logic [8:0] rom [256];

  int   m_cnt;
  logic m_done;
  logic m_ov;

  localparam logic [31:0] RESET_VEC = 32'h0040_0000;

  typedef struct {
    logic       layer;
    logic [3:0] nk;
    logic [7:0] base;
    int         lat;
    int         exp_done;
    int         exp_win;
    int         exp_start;
    int         exp_tv;
  } vec_t;

  vec_t tbl [5];

  conv_sched_if #(.KIDX_W(4)) bus ();

  conv_sched #(
    .KIDX_W   (4),
    .CONV_DLY (1)
`ifdef CONV_SCHED_WDOG_EN
    ,
    .WDOG_CYC (64)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // weight ROM: word valid the cycle after the read strobe
  always @(posedge clk) begin
    if (bus.wt_rd) bus.wt_data <= rom[bus.wt_addr];
  end

  // conv engine model: done after conv_lat cycles of conv_start, one ovalid per kernel
  always @(posedge clk) begin
    if (rst || !bus.conv_start) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_ov   <= 1'b0;
    end else begin
      m_cnt  <= m_cnt + 1;
      m_done <= !withhold && (m_cnt == conv_lat - 1);
      m_ov   <= (m_cnt == 2);
    end
  end

  assign bus.conv_done   = m_done;
  assign bus.conv_ovalid = m_ov | ovalid_ext;

  always @(negedge clk) begin
    if (bus.err) err_seen <= 1'b1;
  end

  function automatic logic [31:0] pack();
    return {9'b0, bus.cmd_ready, bus.busy, bus.wt_rd, bus.conv_weight_en, bus.conv_weight,
            bus.win_start, bus.conv_start, bus.tag_valid, bus.all_done, bus.err,
            bus.conv_state, bus.wt_addr, bus.tag_kidx};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v, input int idx);
    int cyc, rd_n, done_n, done_at, win_n, start_n, tv_n, st_bad, bl, k;
    logic [15:0] wv;
    rd_n = 0; done_n = 0; done_at = -1; win_n = 0; start_n = 0;
    tv_n = 0; st_bad = 0; bl = 0; k = 0; wv = '0;
    conv_lat = v.lat;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_layer = v.layer;
    bus.cmd_nk    = v.nk;
    bus.cmd_base  = v.base;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    cyc = 1;
    while (cyc <= v.exp_done + 20) begin
      if (bus.wt_rd) begin
        check("wt_addr", int'(bus.wt_addr), int'(8'(v.base + 8'(rd_n))));
        check("tag_kidx_at_rd", int'(bus.tag_kidx), rd_n);
        rd_n++;
      end
      if (bus.conv_weight_en) begin
        if (bl < 16) wv[bl] = bus.conv_weight;
        bl++;
      end else if (bl != 0) begin
        check("wt_len", bl, 10);
        check("wt_bits", int'(wv[9:0]), int'({rom[8'(v.base + 8'(k))], 1'b0}));
        k++;
        bl = 0;
        wv = '0;
      end
      win_n   += int'(bus.win_start);
      start_n += int'(bus.conv_start);
      tv_n    += int'(bus.tag_valid);
      if (bus.busy && (bus.conv_state !== v.layer)) st_bad++;
      if (bus.all_done) begin
        done_n++;
        if (done_at < 0) done_at = cyc;
      end
      if (done_at >= 0 && cyc >= done_at + 3) break;
      @(negedge clk);
      cyc++;
    end
    check("done_at", done_at, v.exp_done);
    check("done_count", done_n, 1);
    check("rd_count", rd_n, int'(v.nk));
    check("wt_bursts", k, int'(v.nk));
    check("win_cycles", win_n, v.exp_win);
    check("start_cycles", start_n, v.exp_start);
    check("tag_valid_count", tv_n, v.exp_tv);
    check("conv_state_held", st_bad, 0);
    check("conv_state_latched", int'(bus.conv_state), int'(v.layer));
    check("idle_after", int'({bus.busy, bus.cmd_ready}), 1);
    $display("cmd %0d layer=%0d nk=%0d base=%02h lat=%0d all_done_at=%0d rd=%0d",
             idx, v.layer, v.nk, v.base, v.lat, done_at, rd_n);
  endtask

  initial begin
    int   n;
    int   cyc;
    int   rdy_seen;
    int   tv_seen;
    logic [31:0] acc;
    vec_t v;

    checks = 0;
    errors = 0;
    for (int a = 0; a < 256; a++) rom[a] = 9'((a * 37 + 11) ^ (a << 3));
    rom[8'h10] = 9'b101100111;

    //            layer nk     base   lat  done win  start tv
    tbl[0] = '{1'b0, 4'd1,  8'h10, 20,  36,  22,  21,   1};
`ifdef CONV_SCHED_WDOG_EN
    tbl[1] = '{1'b1, 4'd3,  8'h40, 50,  196, 156, 153,  3};
`else
    tbl[1] = '{1'b1, 4'd3,  8'h40, 300, 946, 906, 903,  3};
`endif
    tbl[2] = '{1'b0, 4'd0,  8'h20, 10,  1,   0,   0,    0};
    tbl[3] = '{1'b1, 4'd2,  8'hFF, 5,   41,  14,  12,   2};
    tbl[4] = '{1'b0, 4'd15, 8'h80, 6,   316, 120, 105,  15};

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_layer = 1'b0;
    bus.cmd_nk    = '0;
    bus.cmd_base  = '0;
    conv_lat      = 10;
    withhold      = 1'b0;
    ovalid_ext    = 1'b0;
    err_seen      = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_state", int'(pack()), int'(RESET_VEC));
    rst = 1'b0;
    acc = '0;
    repeat (20) begin
      @(negedge clk);
      acc = acc | (pack() ^ RESET_VEC);
    end
    check("idle_20", int'(acc), 0);
    $display("reset+idle checked");

    for (int i = 0; i < 5; i++) run_cmd(tbl[i], i);

    // reset mid-LOAD, with a spurious command and ovalid held during the busy phase
    conv_lat = 8;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_layer = 1'b0;
    bus.cmd_nk    = 4'd2;
    bus.cmd_base  = 8'h30;
    @(negedge clk);
    bus.cmd_layer = 1'b1;
    bus.cmd_nk    = 4'd7;
    ovalid_ext    = 1'b1;
    n = 0; cyc = 0; rdy_seen = 0; tv_seen = 0;
    while (n < 3 && cyc < 20) begin
      if (bus.conv_weight_en) n++;
      rdy_seen += int'(bus.cmd_ready);
      tv_seen  += int'(bus.tag_valid);
      @(negedge clk);
      cyc++;
    end
    check("rst_reach_load", n, 3);
    check("ready_low_busy", rdy_seen, 0);
    check("tag_outside_run", tv_seen, 0);
    check("state_not_relatched", int'(bus.conv_state), 0);
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    ovalid_ext    = 1'b0;
    @(negedge clk);
    check("rst_mid_load", int'(pack()), int'(RESET_VEC));
    rst = 1'b0;
    acc = '0;
    repeat (5) begin
      @(negedge clk);
      acc = acc | (pack() ^ RESET_VEC);
    end
    check("rst_no_all_done", int'(acc), 0);
    $display("reset mid-LOAD checked");
    v = '{1'b1, 4'd2, 8'h50, 8, 47, 20, 18, 2};
    run_cmd(v, 5);

`ifdef CONV_SCHED_WDOG_EN
    withhold = 1'b1;
    conv_lat = 10;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_layer = 1'b1;
    bus.cmd_nk    = 4'd2;
    bus.cmd_base  = 8'h60;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!bus.win_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wdog_reach_run", int'(bus.win_start), 1);
    repeat (63) @(negedge clk);
    check("wdog_pre", int'({bus.err, bus.win_start, bus.busy}), 3);
    @(negedge clk);
    check("wdog_err", int'({bus.err, bus.win_start, bus.conv_start, bus.busy, bus.cmd_ready}), 17);
    acc = '0;
    repeat (10) begin
      @(negedge clk);
      acc = acc | {30'b0, bus.all_done, bus.err};
    end
    check("wdog_after", int'(acc), 0);
    withhold = 1'b0;
    $display("watchdog abort checked");
`else
    check("err_tied_low", int'(err_seen), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
